// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keystroke generator: state encoding,
// frame geometry, request payload and set-2 scan-code constants.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    CLK_LOW  = 3'd2,
    CLK_HIGH = 3'd3,
    GAP      = 3'd4
  } ps2_state_t;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned BIT_CNT_W  = 4;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] KEY_B        = 8'h32;
  localparam logic [7:0] KEY_C        = 8'h21;
  localparam logic [7:0] KEY_ENTER    = 8'h5A;

  // Latched keystroke; brk doubles as "second byte still pending" once F0 is out.
  typedef struct packed {
    logic       brk;
    logic [7:0] code;
  } key_req_t;

endpackage

// File: rtl/ps2_frame_shifter.sv
// Holds one 11-bit PS/2 frame (start, 8 data LSB first, odd parity, stop),
// presents the current bit and counts how many bits have been shifted out.
module ps2_frame_shifter
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       shift,
  output logic       data,
  output logic       last_c
);

  logic [FRAME_BITS-1:0] frame_q;
  logic [BIT_CNT_W-1:0]  cnt_q;
  logic                  parity_c;

  // Odd parity: data ones plus parity bit must be odd.
  assign parity_c = ~^load_byte;

  // Ones shift in from the top so the line idles high once the frame is out.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '1;
      cnt_q   <= '0;
    end else if (load) begin
      frame_q <= {1'b1, parity_c, load_byte, 1'b0};
      cnt_q   <= '0;
    end else if (shift) begin
      frame_q <= {1'b1, frame_q[FRAME_BITS-1:1]};
      cnt_q   <= cnt_q + BIT_CNT_W'(1);
    end
  end

  assign data   = frame_q[0];
  assign last_c = (cnt_q == BIT_CNT_W'(FRAME_BITS));

endmodule

// File: rtl/ps2_keystroke_gen.sv
// Device-side PS/2 keystroke generator: accepts a scan code (optionally as a
// break with F0 prefix) and emits it as PS/2 clock/data frames.
module ps2_keystroke_gen
  import ps2_pkg::*;
#(
  parameter int unsigned clk_mhz = 25,
  parameter int unsigned ps2_khz = 12,
  parameter int unsigned gap_us  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [7:0] key_code,
  input  logic       key_release,
  output logic       ps2clk,
  output logic       ps2data,
  output logic       busy
);

  localparam int unsigned HALF_CYC = clk_mhz * 1000 / (2 * ps2_khz);
  localparam int unsigned GAP_CYC  = clk_mhz * gap_us;
  localparam int unsigned MAX_CYC  = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
  localparam int unsigned TIMER_W  = $clog2(MAX_CYC + 1);

  localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(HALF_CYC - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYC - 1);

  ps2_state_t         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  key_req_t           req_q, req_d;
  logic               timer_done_c;
  logic               load_c;
  logic               shift_c;
  logic [7:0]         load_byte_c;
  logic               last_bit_c;

  assign timer_done_c = (timer_q == '0);

  ps2_frame_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (load_c),
    .load_byte (load_byte_c),
    .shift     (shift_c),
    .data      (ps2data),
    .last_c    (last_bit_c)
  );

  // State, timer and registered line outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      req_q     <= '0;
      ps2clk    <= 1'b1;
      busy      <= 1'b0;
      key_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      req_q     <= req_d;
      ps2clk    <= (state_d != CLK_LOW);
      busy      <= (state_d != IDLE);
      key_ready <= (state_d == IDLE);
    end
  end

  // Next-state, shifter control and timer reload on every state change.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    req_d       = req_q;
    load_c      = 1'b0;
    shift_c     = 1'b0;
    load_byte_c = req_q.code;

    unique case (state_q)
      IDLE: begin
        if (key_valid && key_ready) begin
          state_d     = SETUP;
          load_c      = 1'b1;
          load_byte_c = key_release ? BREAK_PREFIX : key_code;
          req_d.brk   = key_release;
          req_d.code  = key_code;
        end
      end
      SETUP: begin
        if (timer_done_c) state_d = CLK_LOW;
      end
      CLK_LOW: begin
        if (timer_done_c) begin
          state_d = CLK_HIGH;
          shift_c = 1'b1;
        end
      end
      CLK_HIGH: begin
        if (timer_done_c) state_d = last_bit_c ? GAP : CLK_LOW;
      end
      GAP: begin
        if (timer_done_c) begin
          if (req_q.brk) begin
            state_d     = SETUP;
            load_c      = 1'b1;
            load_byte_c = req_q.code;
            req_d.brk   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      timer_d = (state_d == GAP) ? GAP_LOAD : HALF_LOAD;
    end else if (!timer_done_c) begin
      timer_d = timer_q - TIMER_W'(1);
    end
  end

endmodule

// File: tb/tb_ps2_keystroke_gen.sv
// Randomized and directed bench for ps2_keystroke_gen against a cycle-level
// waveform model built from the frame rules (HALF=4, GAP=8).
module tb_ps2_keystroke_gen;
  import ps2_pkg::*;

  localparam int unsigned HALF = 4;
  localparam int unsigned GAPC = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_release;
  logic       ps2clk;
  logic       ps2data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Model: queue of expected {ps2clk, ps2data} for every busy cycle still to come.
  logic [1:0] exp_q[$];
  logic       m_clk = 1'b1, m_data = 1'b1, m_busy = 1'b0, m_ready = 1'b0;
  int         accepts = 0;

  logic       fall_q[$];
  logic       prev_clk = 1'b1;
  int         busy_cycles = 0;
  int         ready_in_busy = 0;
  int         low_run = 0;

  ps2_keystroke_gen #(.clk_mhz(1), .ps2_khz(125), .gap_us(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_code    (key_code),
    .key_release (key_release),
    .ps2clk      (ps2clk),
    .ps2data     (ps2data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte on the wire: 23 half-periods (setup + 11 low/high pairs) then the gap.
  task automatic push_byte(input logic [7:0] b);
    logic [10:0] fr;
    int          ph;
    logic [3:0]  bi;
    fr = {1'b1, ~^b, b, 1'b0};
    for (int t = 0; t < 23 * HALF; t++) begin
      ph = t / HALF;
      bi = 4'(ph / 2);
      exp_q.push_back({(ph % 2) == 0, (bi > 4'd10) ? 1'b1 : fr[bi]});
    end
    for (int g = 0; g < GAPC; g++) exp_q.push_back(2'b11);
  endtask

  function automatic logic [10:0] fall_vec(input int start);
    logic [10:0] v;
    for (int i = 0; i < 11; i++)
      v[i] = (start + i < fall_q.size()) ? fall_q[start + i] : 1'bx;
    return v;
  endfunction

  // Advance model and DUT by one clock, then compare outputs mid-cycle.
  task automatic tick();
    logic [1:0] e;
    if (reset) begin
      exp_q.delete();
      m_clk = 1'b1; m_data = 1'b1; m_busy = 1'b0; m_ready = 1'b0;
    end else begin
      if (m_ready && key_valid) begin
        accepts++;
        if (key_release) push_byte(BREAK_PREFIX);
        push_byte(key_code);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_clk = e[1]; m_data = e[0]; m_busy = 1'b1; m_ready = 1'b0;
      end else begin
        m_clk = 1'b1; m_data = 1'b1; m_busy = 1'b0; m_ready = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("outputs{clk,data,busy,ready}", {28'd0, ps2clk, ps2data, busy, key_ready},
          {28'd0, m_clk, m_data, m_busy, m_ready});
    if (prev_clk && !ps2clk) fall_q.push_back(ps2data);
    prev_clk = ps2clk;
    if (busy) busy_cycles++;
    if (busy && key_ready) ready_in_busy++;
    if (reset) low_run = 0;
    else if (!ps2clk) low_run++;
    else if (low_run > 0) begin
      check("low_phase_len", 32'(low_run), 32'(HALF));
      low_run = 0;
    end
  endtask

  task automatic run_until_idle(input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic clear_obs();
    fall_q.delete();
    busy_cycles   = 0;
    ready_in_busy = 0;
  endtask

  initial begin
    int a0;
    int n;
    reset = 1'b1; key_valid = 1'b0; key_code = 8'h00; key_release = 1'b0;

    // Reset state and first cycle after release.
    repeat (3) tick();
    check("reset_lines", {29'd0, ps2clk, ps2data, busy}, 32'b110);
    check("reset_ready", {31'd0, key_ready}, 32'd0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", {31'd0, key_ready}, 32'd1);

    // Make code 0x32.
    clear_obs();
    key_code = KEY_B; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    run_until_idle(300);
    check("make32_busy_cycles", 32'(busy_cycles), 32'd100);
    check("make32_falls", 32'(fall_q.size()), 32'd11);
    check("make32_bits", {21'd0, fall_vec(0)}, 32'h464);

    // Back-to-back 0x5A then 0xFF with key_valid held.
    clear_obs();
    a0 = accepts;
    key_code = KEY_ENTER; key_valid = 1'b1;
    tick();
    key_code = 8'hFF;
    n = 0;
    while (accepts < a0 + 2 && n < 400) begin
      tick();
      n++;
    end
    key_valid = 1'b0;
    run_until_idle(300);
    check("b2b_accepts", 32'(accepts - a0), 32'd2);
    check("b2b_falls", 32'(fall_q.size()), 32'd22);
    check("b2b_first", {21'd0, fall_vec(0)}, 32'h6B4);
    check("b2b_second", {21'd0, fall_vec(11)}, 32'h7FE);
    check("b2b_busy_cycles", 32'(busy_cycles), 32'd200);
    check("b2b_ready_in_busy", 32'(ready_in_busy), 32'd0);

    // Break of 0x21: F0 then 21 from a single handshake; inputs scrambled while busy.
    clear_obs();
    a0 = accepts;
    key_code = KEY_C; key_release = 1'b1; key_valid = 1'b1;
    tick();
    key_valid = 1'b0; key_release = 1'b0; key_code = 8'($urandom);
    run_until_idle(400);
    check("break_accepts", 32'(accepts - a0), 32'd1);
    check("break_falls", 32'(fall_q.size()), 32'd22);
    check("break_f0", {21'd0, fall_vec(0)}, 32'h7E0);
    check("break_code", {21'd0, fall_vec(11)}, 32'h642);
    check("break_busy_cycles", 32'(busy_cycles), 32'd200);

    // Reset 30 cycles into a frame aborts it.
    key_code = KEY_B; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (29) tick();
    reset = 1'b1;
    tick();
    check("abort_lines", {29'd0, ps2clk, ps2data, busy}, 32'b110);
    reset = 1'b0;
    clear_obs();
    tick();
    check("abort_ready", {31'd0, key_ready}, 32'd1);
    repeat (120) tick();
    check("abort_no_edges", 32'(fall_q.size()), 32'd0);
    check("abort_no_busy", 32'(busy_cycles), 32'd0);

    // Reset wins over a simultaneous request.
    a0 = accepts;
    reset = 1'b1; key_valid = 1'b1; key_code = KEY_ENTER;
    repeat (2) tick();
    reset = 1'b0; key_valid = 1'b0;
    clear_obs();
    repeat (60) tick();
    check("rst_vs_valid_accepts", 32'(accepts - a0), 32'd0);
    check("rst_vs_valid_edges", 32'(fall_q.size()), 32'd0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 399) == 0);
      key_valid   = ($urandom_range(0, 3) != 0);
      key_code    = 8'($urandom);
      key_release = ($urandom_range(0, 2) == 0);
      tick();
    end
    reset = 1'b0; key_valid = 1'b0;
    run_until_idle(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_keystroke_gen.md
PS2_KEYSTROKE_GEN -- requirements
Module: ps2_keystroke_gen

Interface
REQ-001 Parameter clk_mhz, default 25, is the clock frequency in MHz.
REQ-002 Parameter ps2_khz, default 12, is the PS/2 clock frequency in kHz; HALF = clk_mhz*1000/(2*ps2_khz) cycles, integer division, and SHALL be at least 2.
REQ-003 Parameter gap_us, default 100, is the idle gap after each byte; GAP = clk_mhz*gap_us cycles.
REQ-004 Port clk  in  1  is the single clock; all logic SHALL be rising-edge.
REQ-005 Port reset  in  1  is synchronous, active-high reset.
REQ-006 Port key_valid  in  1  means a keystroke request is present.
REQ-007 Port key_ready  out  1  means the block accepts a request this cycle.
REQ-008 Port key_code  in  8  is the PS/2 set-2 scan code.
REQ-009 Port key_release  in  1  selects a break (send F0 then key_code) instead of a make code.
REQ-010 Port ps2clk  out  1  is the PS/2 clock toward the orao core ps2clk input.
REQ-011 Port ps2data  out  1  is the PS/2 data toward the orao core ps2data input.
REQ-012 Port busy  out  1  is high from acceptance until return to IDLE.

Function
REQ-013 Handshake: a request SHALL be accepted on a cycle where key_valid && key_ready; key_code and key_release SHALL be latched on that cycle.
REQ-014 key_ready SHALL be 1 only in IDLE; a request held during busy SHALL wait, not be dropped.
REQ-015 FSM states SHALL be IDLE, SETUP, CLK_LOW, CLK_HIGH, GAP.
- IDLE: on accept, go to SETUP.
- SETUP: lasts HALF cycles.
- CLK_LOW and CLK_HIGH: HALF cycles each, 11 times.
- GAP: lasts GAP cycles, then IDLE or the next byte's SETUP.
REQ-016 Frame SHALL be start 0, data bits 0..7 LSB first, odd parity, then stop 1.
REQ-017 ps2data SHALL show the start bit from the first cycle of SETUP, with ps2clk high.
REQ-018 Each following bit SHALL change only on the cycle ps2clk returns high.
REQ-019 ps2clk SHALL fall exactly HALF cycles after each data change, giving 11 falling edges per frame.
REQ-020 Frame length SHALL be 23*HALF cycles from the first SETUP cycle to GAP entry.
REQ-021 During GAP and IDLE, ps2clk=1 and ps2data=1.
REQ-022 Parity bit SHALL make the count of ones in the data bits plus the parity bit odd.
REQ-023 With key_release=1, byte F0 SHALL be sent first, then GAP, then key_code, then GAP, then IDLE, all without re-handshake.
REQ-024 key_valid/key_code changes during busy SHALL NOT affect the frame in progress.
REQ-025 The timer SHALL be a down-counter reloaded at each state entry with no wrap-around; both HALF and GAP SHALL be counted exactly.

Reset
REQ-026 When reset=1, next cycle state SHALL be IDLE, with ps2clk=1, ps2data=1, busy=0, key_ready=0 while reset is asserted, and key_ready=1 on the first cycle after release.
REQ-027 Reset mid-frame or mid-break SHALL abort immediately; a pending second byte SHALL be discarded and no partial bits emitted afterward.
REQ-028 Reset SHALL have priority over a simultaneous key_valid.

Structure
REQ-029 The shared package/include ps2_pkg SHALL hold:
- the state encodings;
- scan-code constants BREAK_PREFIX=8'hF0, KEY_B=8'h32, KEY_C=8'h21, KEY_ENTER=8'h5A.
REQ-030 One sub-module, ps2_frame_shifter, SHALL hold the 11-bit frame register, parity generation and bit counter; the FSM and timer remain in the top.

Verification (clk_mhz=1, ps2_khz=125 -> HALF=4; gap_us=8 -> GAP=8)
REQ-031 Make 8'h32: sample ps2data at each ps2clk fall -> 0,0,1,0,0,1,1,0,0,0,1 (parity 0); busy high 92+8=100 cycles.
REQ-032 Make 8'h5A then 8'hFF back-to-back with key_valid held:
- second accepted only after GAP;
- parity bits 1 and 1;
- key_ready low throughout busy.
REQ-033 Break 8'h21: frames F0 (bits 0,0,0,0,0,1,1,1,1,1,1) then 21 (parity 1), separated by 8 idle-high cycles; single handshake.
REQ-034 Reset asserted at cycle 30 of a frame -> ps2clk=ps2data=1 next cycle, busy=0, key_ready=1 first cycle after release, no further edges.
REQ-035 Reset and key_valid high in the same cycle -> no accept, no frame; frame period checker confirms every low/high phase is exactly 4 cycles.
